pipelined_logic_gate_n: RTL and testbench
=========================================

Name: pipelined_logic_gate_n

Overview:
- Parametrised successor to the fixed 4-input combinational gates.
- N-input, W-bit-wide bitwise reduction gate, selectable as AND, OR or XOR, with optional output inversion (NAND, NOR or XNOR) and a per-input bubble mask.
- Result passes through a configurable-depth valid/ready pipeline with full backpressure.
- Used in the CPU datapath wherever wide gate trees must be registered to meet timing.

Parameters:
- NumInputs, 4, number of operand inputs (2..16).
- BitWidth, 1, bits per operand and result (1..32).
- Mode, 1, reduction function: 0 AND, 1 OR, 2 XOR; 3 is illegal and is flagged by a simulation-time error.
- InvertOutput, 1, 1 inverts the reduced result (default configuration = NOR).
- BubblesMask, 0, NumInputs-bit mask; bit i set inverts all bits of operand i before reduction.
- PipeStages, 2, number of register stages (1..4).

Ports:
- GlobalClock  input  1  single clock; all state changes on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- ClockEnable  input  1  when 0, all state holds and In_Ready is forced to 0.
- Inputs  input  NumInputs*BitWidth  flattened operands; operand i = bits [i*BitWidth +: BitWidth].
- In_Valid  input  1  operands valid this cycle.
- In_Ready  output  1  block can accept operands this cycle.
- Result  output  BitWidth  gate output of the head pipeline stage.
- Out_Valid  output  1  Result is valid.
- Out_Ready  input  1  downstream accepts Result.

Behaviour:
- Interface: one clock (GlobalClock); reset nReset is asynchronous and active-low.
- Reset (nReset=0, asynchronous):
  - all stage valid bits = 0 and all stage data = 0;
  - outputs: Out_Valid=0, Result=0, In_Ready=0 while asserted.
- Release of reset is synchronous to the next rising edge; In_Ready rises combinationally once nReset=1 and ClockEnable=1.
- Combinational front end:
  - real operand i = BubblesMask[i] ? ~operand i : operand i;
  - reduce bitwise across all operands per Mode;
  - XOR with {BitWidth{InvertOutput}}.
- Pipeline: stages S0 (input side) .. S[PipeStages-1] (output side), each holding a data register and a valid bit.
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when Out_Ready=1.
  - In_Ready = ClockEnable & (S0 empty | S0 advances), derived combinationally from Out_Ready down through the chain.
- Transfer rules:
  - an input transfer occurs when In_Valid & In_Ready;
  - an output transfer occurs when Out_Valid & Out_Ready;
  - in the same edge, S0 loads the front-end value and its valid bit is set to the input transfer.
- Latency: PipeStages cycles from input transfer to Out_Valid when there is no backpressure.
- Throughput: 1 result per cycle with Out_Ready held 1.
- Backpressure: with Out_Ready=0, the pipe fills and then In_Ready=0; exactly PipeStages items are held, none lost or duplicated.
- Simultaneous input and output transfer while full: allowed and no bubble is inserted, i.e. full throughput.
- Result and Out_Valid are registered outputs (last stage); there is no combinational path from Inputs to Result.
- Result holds stable while Out_Valid=1 and Out_Ready=0.
- ClockEnable=0: no register changes and In_Ready=0. Out_Valid and Result hold, but no output transfer is counted, because the last stage cannot advance.
- Reset mid-operation: all in-flight items are discarded; Out_Valid drops asynchronously.

Optional Feature:
- Macro: GATE_TRANSFER_COUNT_EN.
- Defined:
  - adds output port Xfer_Count [15:0], a saturating count of output transfers whose Result is nonzero;
  - resets to 0 on nReset;
  - holds at 16'hFFFF once reached;
  - frozen when ClockEnable=0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Default configuration (4x1-bit NOR, 2 stages), Out_Ready=1, stream Inputs=4'b0000, 4'b0100, 4'b1111 on consecutive cycles -> Result 1, 0, 0 with Out_Valid high exactly 2 cycles after each input transfer.
- BitWidth=8, NumInputs=3, Mode=0, InvertOutput=0, BubblesMask=3'b010, operands 8'hF0, 8'h0F, 8'hFF -> Result 8'hF0.
- PipeStages=3, hold Out_Ready=0, offer 5 items -> In_Ready falls after 3 accepted. Then release Out_Ready -> 3 items emerge in order, and the 4th is accepted on the same edge the first leaves.
- Mode=2, InvertOutput=1, NumInputs=4, BitWidth=4, operands 4'h1, 4'h2, 4'h4, 4'h8 -> Result 4'h0; alternate ClockEnable 0/1 -> no item lost or duplicated.
- Assert nReset with 2 items in flight -> Out_Valid=0 and Result=0 immediately; after release, the first new item appears with normal latency, and no stale data is observed.
- GATE_TRANSFER_COUNT_EN defined, default configuration: 3 transfers with all inputs 0, then 2 with input 4'b0001 -> Xfer_Count=3. Preload the counter by forcing it to 16'hFFFE, then 3 more nonzero transfers -> Xfer_Count=16'hFFFF.

Source files
------------

// File: rtl/pipelined_logic_gate_n.sv
// N-input, W-bit bitwise AND/OR/XOR gate (optional output inversion and per-input bubbles)
// registered through a valid/ready pipeline. Define GATE_TRANSFER_COUNT_EN to add Xfer_Count.
module pipelined_logic_gate_n #(
  parameter int                   NumInputs    = 4,
  parameter int                   BitWidth     = 1,
  parameter int                   Mode         = 1,
  parameter bit                   InvertOutput = 1'b1,
  parameter logic [NumInputs-1:0] BubblesMask  = '0,
  parameter int                   PipeStages   = 2
) (
  input  logic                          GlobalClock,
  input  logic                          nReset,
  input  logic                          ClockEnable,
  input  logic [NumInputs*BitWidth-1:0] Inputs,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  output logic [BitWidth-1:0]           Result,
  output logic                          Out_Valid,
`ifdef GATE_TRANSFER_COUNT_EN
  output logic [15:0]                   Xfer_Count,
`endif
  input  logic                          Out_Ready
);

  localparam int ModeAnd = 0;
  localparam int ModeOr  = 1;
  localparam int ModeXor = 2;
  localparam int Last    = PipeStages - 1;

  if (Mode > ModeXor || Mode < ModeAnd) begin : g_bad_mode
    $error("pipelined_logic_gate_n: Mode %0d is illegal (0 AND, 1 OR, 2 XOR)", Mode);
  end
  if (NumInputs < 2 || NumInputs > 16) begin : g_bad_inputs
    $error("pipelined_logic_gate_n: NumInputs %0d out of range 2..16", NumInputs);
  end
  if (BitWidth < 1 || BitWidth > 32) begin : g_bad_width
    $error("pipelined_logic_gate_n: BitWidth %0d out of range 1..32", BitWidth);
  end
  if (PipeStages < 1 || PipeStages > 4) begin : g_bad_stages
    $error("pipelined_logic_gate_n: PipeStages %0d out of range 1..4", PipeStages);
  end

  // Combinational front end: bubble, reduce, optionally invert.
  logic [BitWidth-1:0] front_value;

  always_comb begin
    logic [BitWidth-1:0] operand;
    logic [BitWidth-1:0] reduced;
    // NOTE: every variable gets a value on every path before use, otherwise a latch is inferred.
    operand = '0;
    reduced = (Mode == ModeAnd) ? '1 : '0;
    for (int i = 0; i < NumInputs; i++) begin
      operand = Inputs[i*BitWidth +: BitWidth] ^ {BitWidth{BubblesMask[i]}};
      if (Mode == ModeAnd)     reduced = reduced & operand;
      else if (Mode == ModeOr) reduced = reduced | operand;
      else                     reduced = reduced ^ operand;
    end
    front_value = reduced ^ {BitWidth{InvertOutput}};
  end

  // Pipeline state and handshake
  logic [PipeStages-1:0] stage_valid;
  logic [BitWidth-1:0]   stage_data [PipeStages];
  logic [PipeStages-1:0] advance;
  logic [PipeStages-1:0] load_valid;
  logic [BitWidth-1:0]   load_data  [PipeStages];
  logic                  in_xfer;

  // Advance ripples from Out_Ready at the head back to S0, so a full pipe still streams.
  always_comb begin
    logic chain;
    advance       = '0;
    chain         = ClockEnable & (~stage_valid[Last] | Out_Ready);
    advance[Last] = chain;
    for (int k = PipeStages - 2; k >= 0; k--) begin
      chain      = ClockEnable & (~stage_valid[k] | chain);
      advance[k] = chain;
    end
  end

  assign In_Ready = nReset & advance[0];
  assign in_xfer  = In_Valid & In_Ready;

  always_comb begin
    load_valid[0] = in_xfer;
    load_data[0]  = front_value;
    for (int k = 1; k < PipeStages; k++) begin
      load_valid[k] = stage_valid[k-1];
      load_data[k]  = stage_data[k-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge GlobalClock or negedge nReset) begin
    if (!nReset) begin
      stage_valid <= '0;
      // NOTE: the data array is reset too, because Result must read 0 while in reset.
      for (int k = 0; k < PipeStages; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PipeStages; k++) begin
        if (advance[k]) begin
          stage_valid[k] <= load_valid[k];
          if (load_valid[k]) begin
            stage_data[k] <= load_data[k];
          end
        end
      end
    end
  end

  assign Out_Valid = stage_valid[Last];
  assign Result    = stage_data[Last];

`ifdef GATE_TRANSFER_COUNT_EN
  // Saturating count of output transfers carrying a nonzero Result.
  logic [15:0] xfer_count;

  always_ff @(posedge GlobalClock or negedge nReset) begin
    if (!nReset) begin
      xfer_count <= '0;
    end else if (advance[Last] && stage_valid[Last] && (|stage_data[Last])
                 && (xfer_count != 16'hFFFF)) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

  assign Xfer_Count = xfer_count;
`endif

endmodule

// File: tb/tb_pipelined_logic_gate_n.sv
// Scoreboard bench: three gate configurations share clock and reset; a monitor pops and compares
// expected results whenever a DUT performs an output transfer.
module tb_pipelined_logic_gate_n;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cycle_count = 0;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: default 4x1 NOR, 2 stages
  logic        ce_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [3:0]  inputs_a;
  logic [0:0]  result_a;
  // DUT B: 3x8 AND, bubble on operand 1, 3 stages
  logic        ce_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [23:0] inputs_b;
  logic [7:0]  result_b;
  // DUT C: 4x4 XNOR, 4 stages
  logic        ce_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [15:0] inputs_c;
  logic [3:0]  result_c;
`ifdef GATE_TRANSFER_COUNT_EN
  logic [15:0] xfer_count_a, xfer_count_b, xfer_count_c;
`endif

  pipelined_logic_gate_n u_a (
    .GlobalClock(clk), .nReset(rst_n), .ClockEnable(ce_a), .Inputs(inputs_a),
    .In_Valid(in_valid_a), .In_Ready(in_ready_a), .Result(result_a), .Out_Valid(out_valid_a),
`ifdef GATE_TRANSFER_COUNT_EN
    .Xfer_Count(xfer_count_a),
`endif
    .Out_Ready(out_ready_a)
  );

  pipelined_logic_gate_n #(
    .NumInputs(3), .BitWidth(8), .Mode(0), .InvertOutput(1'b0),
    .BubblesMask(3'b010), .PipeStages(3)
  ) u_b (
    .GlobalClock(clk), .nReset(rst_n), .ClockEnable(ce_b), .Inputs(inputs_b),
    .In_Valid(in_valid_b), .In_Ready(in_ready_b), .Result(result_b), .Out_Valid(out_valid_b),
`ifdef GATE_TRANSFER_COUNT_EN
    .Xfer_Count(xfer_count_b),
`endif
    .Out_Ready(out_ready_b)
  );

  pipelined_logic_gate_n #(
    .NumInputs(4), .BitWidth(4), .Mode(2), .InvertOutput(1'b1),
    .BubblesMask(4'b0000), .PipeStages(4)
  ) u_c (
    .GlobalClock(clk), .nReset(rst_n), .ClockEnable(ce_c), .Inputs(inputs_c),
    .In_Valid(in_valid_c), .In_Ready(in_ready_c), .Result(result_c), .Out_Valid(out_valid_c),
`ifdef GATE_TRANSFER_COUNT_EN
    .Xfer_Count(xfer_count_c),
`endif
    .Out_Ready(out_ready_c)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  bit   lat_a = 1'b0;

  // Hand-computed vectors: flattened operands and expected result
  logic [23:0] vec_a [5] = '{24'h0, 24'h4, 24'hF, 24'h8, 24'h0};
  logic [7:0]  res_a [5] = '{8'h1, 8'h0, 8'h0, 8'h0, 8'h1};
  logic [23:0] vec_b [5] = '{24'hFF0FF0, 24'hFF00FF, 24'hFF55AA, 24'hFFFFFF, 24'h0FC33C};
  logic [7:0]  res_b [5] = '{8'hF0, 8'hFF, 8'hAA, 8'h00, 8'h0C};
  logic [23:0] vec_c [6] = '{24'h8421, 24'h0000, 24'h0053, 24'h1111, 24'h100C, 24'h7000};
  logic [7:0]  res_c [6] = '{8'h0, 8'hF, 8'h9, 8'hF, 8'h2, 8'h8};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] actual);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got output %0h expected no output", name, actual);
  endtask

  // Monitor: samples 2 time units after the falling edge, after all stimulus has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ce_a && out_valid_a && out_ready_a) begin
        if (q_a.size() == 0) unexpected("a_extra_output", 8'(result_a));
        else begin
          e = q_a.pop_front();
          check("a_result", 32'(result_a), 32'(e.data));
          if (lat_a) check("a_latency", cycle_count - e.cyc, 32'd2);
        end
      end
      if (rst_n && ce_b && out_valid_b && out_ready_b) begin
        if (q_b.size() == 0) unexpected("b_extra_output", result_b);
        else begin
          e = q_b.pop_front();
          check("b_result", 32'(result_b), 32'(e.data));
        end
      end
      if (rst_n && ce_c && out_valid_c && out_ready_c) begin
        if (q_c.size() == 0) unexpected("c_extra_output", 8'(result_c));
        else begin
          e = q_c.pop_front();
          check("c_result", 32'(result_c), 32'(e.data));
        end
      end
    end
  end

  // Called at a falling edge; returns at a later falling edge with In_Valid dropped.
  task automatic send(input int which, input logic [23:0] vec, input logic [7:0] expv,
                      output int tries);
    exp_t e;
    logic rdy;
    tries = 0;
    rdy   = 1'b0;
    case (which)
      0:       begin inputs_a = vec[3:0];  in_valid_a = 1'b1; end
      1:       begin inputs_b = vec;       in_valid_b = 1'b1; end
      default: begin inputs_c = vec[15:0]; in_valid_c = 1'b1; end
    endcase
    while (!rdy && tries < 100) begin
      #1;
      tries++;
      case (which)
        0:       rdy = in_ready_a;
        1:       rdy = in_ready_b;
        default: rdy = in_ready_c;
      endcase
      if (!rdy) @(negedge clk);
    end
    if (rdy) begin
      e.data = expv;
      e.cyc  = cycle_count;
      case (which)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: dut %0d got In_Ready=0 for %0d cycles expected acceptance",
               which, tries);
    end
    @(negedge clk);
    case (which)
      0:       in_valid_a = 1'b0;
      1:       in_valid_b = 1'b0;
      default: in_valid_c = 1'b0;
    endcase
  endtask

  task automatic drain(input int which);
    int n = 0;
    int left;
    left = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    while (left != 0 && n < 200) begin
      @(negedge clk);
      n++;
      left = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    end
    check($sformatf("drain_%0d_items_left", which), left, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    {ce_a, ce_b, ce_c} = 3'b111;
    {in_valid_a, in_valid_b, in_valid_c} = 3'b000;
    {out_ready_a, out_ready_b, out_ready_c} = 3'b111;
    inputs_a = '0; inputs_b = '0; inputs_c = '0;

    // Reset state
    #3;
    check("rst_a_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_a_result",    32'(result_a),    32'd0);
    check("rst_a_in_ready",  32'(in_ready_a),  32'd0);
    check("rst_b_out_valid", 32'(out_valid_b), 32'd0);
    check("rst_b_result",    32'(result_b),    32'd0);
    check("rst_c_in_ready",  32'(in_ready_c),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("a_in_ready_after_release", 32'(in_ready_a), 32'd1);
    @(negedge clk);

    // Default NOR, back-to-back stream, latency 2
    lat_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(0, vec_a[i], res_a[i], t);
      check("a_stream_accept_first_try", t, 32'd1);
    end
    drain(0);
    lat_a = 1'b0;

    // Backpressure on the 3-stage AND with bubble
    out_ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1, vec_b[i], res_b[i], t);
      check("b_fill_accept", t, 32'd1);
    end
    in_valid_b = 1'b1;
    inputs_b   = vec_b[3];
    #1;
    check("b_full_in_ready", 32'(in_ready_b), 32'd0);
    check("b_full_out_valid", 32'(out_valid_b), 32'd1);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("b_stall_result_stable", 32'(result_b), 32'(q_b[0].data));
      check("b_stall_in_ready", 32'(in_ready_b), 32'd0);
    end
    @(negedge clk);
    out_ready_b = 1'b1;
    send(1, vec_b[3], res_b[3], t);
    check("b_accept_on_release_edge", t, 32'd1);
    check("b_items_after_release", q_b.size(), 32'd3);
    send(1, vec_b[4], res_b[4], t);
    drain(1);

    // XNOR with ClockEnable toggling every cycle
    fork
      begin
        repeat (40) begin
          @(negedge clk);
          ce_c = ~ce_c;
        end
        ce_c = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) send(2, vec_c[i], res_c[i], t);
      end
    join
    drain(2);

    // Reset with two items in flight
    out_ready_a = 1'b0;
    send(0, 24'h0, 8'h1, t);
    send(0, 24'h0, 8'h1, t);
    #1;
    check("a_inflight_out_valid", 32'(out_valid_a), 32'd1);
    check("a_inflight_result",    32'(result_a),    32'd1);
    #2;
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check("a_midreset_out_valid", 32'(out_valid_a), 32'd0);
    check("a_midreset_result",    32'(result_a),    32'd0);
    check("a_midreset_in_ready",  32'(in_ready_a),  32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    out_ready_a = 1'b1;
    lat_a       = 1'b1;
    send(0, 24'h2, 8'h0, t);
    send(0, 24'h0, 8'h1, t);
    drain(0);
    lat_a = 1'b0;

`ifdef GATE_TRANSFER_COUNT_EN
    rst_n = 1'b0;
    #1;
    check("cnt_reset", 32'(xfer_count_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 24'h0, 8'h1, t);
    for (int i = 0; i < 2; i++) send(0, 24'h1, 8'h0, t);
    drain(0);
    check("cnt_nonzero_only", 32'(xfer_count_a), 32'd3);
    force u_a.xfer_count = 16'hFFFE;
    #1;
    release u_a.xfer_count;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(0, 24'h0, 8'h1, t);
    drain(0);
    check("cnt_saturate", 32'(xfer_count_a), 32'h0000FFFF);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
